// File: rtl/fetch_stage.sv
// IF stage with IF/ID pipeline register for the pipelined RV32I core.
// Owns the fetch PC, next-PC select and the ID-side instruction/PC latch.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        MisalignF
);

    logic [31:0] r_pc;
    logic        r_misalign;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc_plus4_d;
    logic        r_valid_d;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc + 32'd4;

    // A redirect beats StallF so a resolved branch is never dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else if (PCSrcE) begin
            r_pc       <= {PCTargetE[31:2], 2'b00};
            r_misalign <= |PCTargetE[1:0];
        end else if (!StallF) begin
            r_pc <= w_pc_plus4;
        end
    end

    // Flush inserts a bubble but leaves PCD/PCPlus4D untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
            r_valid_d    <= 1'b0;
        end else if (FlushD) begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else if (!StallD) begin
            r_instr_d    <= InstrF;
            r_pc_d       <= r_pc;
            r_pc_plus4_d <= w_pc_plus4;
            r_valid_d    <= 1'b1;
        end
    end

    assign PCF       = r_pc;
    assign MisalignF = r_misalign;
    assign InstrD    = r_instr_d;
    assign PCD       = r_pc_d;
    assign PCPlus4D  = r_pc_plus4_d;
    assign ValidD    = r_valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// Each task drives one scenario and checks against hand-computed values.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] INS = 32'h00A0_0093;

    logic        clk;
    logic        reset;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        MisalignF;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .StallF   (StallF),
        .StallD   (StallD),
        .FlushD   (FlushD),
        .PCSrcE   (PCSrcE),
        .PCTargetE(PCTargetE),
        .InstrF   (InstrF),
        .PCF      (PCF),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PCPlus4D (PCPlus4D),
        .ValidD   (ValidD),
        .MisalignF(MisalignF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        PCSrcE    = 1'b0;
        PCTargetE = 32'd0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        InstrF = INS;
        reset  = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (PCF !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pcf got %h exp %h", PCF, 32'h0);
        end
        n_checks++;
        if (InstrD !== NOP) begin
            n_fail++;
            $display("FAIL reset_instrd got %h exp %h", InstrD, NOP);
        end
        n_checks++;
        if (PCD !== 32'h0 || PCPlus4D !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pcd got %h/%h exp 0/0", PCD, PCPlus4D);
        end
        n_checks++;
        if (ValidD !== 1'b0 || MisalignF !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got v=%b m=%b exp 0/0", ValidD, MisalignF);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pcf [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
        logic [31:0] exp_pcd [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (PCF !== exp_pcf[i]) begin
                n_fail++;
                $display("FAIL seq_pcf[%0d] got %h exp %h", i, PCF, exp_pcf[i]);
            end
            n_checks++;
            if (PCD !== exp_pcd[i] || PCPlus4D !== exp_pcd[i] + 32'd4) begin
                n_fail++;
                $display("FAIL seq_pcd[%0d] got %h/%h exp %h/%h", i, PCD,
                         PCPlus4D, exp_pcd[i], exp_pcd[i] + 32'd4);
            end
            n_checks++;
            if (InstrD !== INS || ValidD !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_instrd[%0d] got %h v=%b exp %h v=1", i,
                         InstrD, ValidD, INS);
            end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        step();
        InstrF = 32'h0020_0113;
        step();
        StallF = 1'b1;
        StallD = 1'b1;
        InstrF = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (PCF !== 32'h8) begin
                n_fail++;
                $display("FAIL stall_pcf[%0d] got %h exp %h", i, PCF, 32'h8);
            end
            n_checks++;
            if (PCD !== 32'h4 || InstrD !== 32'h0020_0113) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] got %h/%h exp 4/00200113", i,
                         PCD, InstrD);
            end
        end
        StallF = 1'b0;
        StallD = 1'b0;
        step();
        n_checks++;
        if (PCF !== 32'hC || PCD !== 32'h8 || InstrD !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL stall_release got %h/%h/%h exp c/8/deadbeef",
                     PCF, PCD, InstrD);
        end
    endtask

    task automatic test_redirect_flush();
        apply_reset();
        repeat (4) step();
        PCSrcE    = 1'b1;
        PCTargetE = 32'h100;
        FlushD    = 1'b1;
        step();
        n_checks++;
        if (PCF !== 32'h100) begin
            n_fail++;
            $display("FAIL redir_pcf got %h exp %h", PCF, 32'h100);
        end
        n_checks++;
        if (InstrD !== NOP || ValidD !== 1'b0 || PCD !== 32'hC) begin
            n_fail++;
            $display("FAIL redir_bubble got %h v=%b pcd=%h exp %h v=0 pcd=c",
                     InstrD, ValidD, PCD, NOP);
        end
        idle_inputs();
        step();
        n_checks++;
        if (PCD !== 32'h100 || ValidD !== 1'b1 || PCPlus4D !== 32'h104) begin
            n_fail++;
            $display("FAIL redir_next got %h v=%b p4=%h exp 100 v=1 p4=104",
                     PCD, ValidD, PCPlus4D);
        end
        n_checks++;
        if (PCF !== 32'h104) begin
            n_fail++;
            $display("FAIL redir_seq got %h exp %h", PCF, 32'h104);
        end
    endtask

    task automatic test_redirect_over_stall();
        apply_reset();
        step();
        PCSrcE    = 1'b1;
        PCTargetE = 32'h40;
        StallF    = 1'b1;
        FlushD    = 1'b1;
        StallD    = 1'b1;
        step();
        n_checks++;
        if (PCF !== 32'h40) begin
            n_fail++;
            $display("FAIL prio_pcf got %h exp %h", PCF, 32'h40);
        end
        n_checks++;
        if (InstrD !== NOP || ValidD !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_bubble got %h v=%b exp %h v=0", InstrD, ValidD, NOP);
        end
        idle_inputs();
    endtask

    task automatic test_misalign();
        apply_reset();
        PCSrcE    = 1'b1;
        PCTargetE = 32'h202;
        step();
        n_checks++;
        if (PCF !== 32'h200 || MisalignF !== 1'b1) begin
            n_fail++;
            $display("FAIL mis_set got %h m=%b exp 200 m=1", PCF, MisalignF);
        end
        idle_inputs();
        step();
        n_checks++;
        if (PCF !== 32'h204 || MisalignF !== 1'b1) begin
            n_fail++;
            $display("FAIL mis_sticky got %h m=%b exp 204 m=1", PCF, MisalignF);
        end
        PCSrcE    = 1'b1;
        PCTargetE = 32'h300;
        step();
        n_checks++;
        if (PCF !== 32'h300 || MisalignF !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_clear got %h m=%b exp 300 m=0", PCF, MisalignF);
        end
        idle_inputs();
    endtask

    task automatic test_wrap_and_reset();
        apply_reset();
        PCSrcE    = 1'b1;
        PCTargetE = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        step();
        n_checks++;
        if (PCF !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_pcf got %h exp %h", PCF, 32'h0);
        end
        n_checks++;
        if (PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_pcd got %h/%h exp fffffffc/0", PCD, PCPlus4D);
        end
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0083;
        step();
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0081;
        StallF    = 1'b1;
        StallD    = 1'b1;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (PCF !== 32'h0 || ValidD !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_stall got %h v=%b exp 0 v=0", PCF, ValidD);
        end
        n_checks++;
        if (MisalignF !== 1'b0 || InstrD !== NOP) begin
            n_fail++;
            $display("FAIL rst_clear got m=%b %h exp m=0 %h", MisalignF, InstrD, NOP);
        end
        idle_inputs();
    endtask

    initial begin
        reset  = 1'b1;
        InstrF = INS;
        idle_inputs();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_flush();
        test_redirect_over_stall();
        test_misalign();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
